// File: rtl/thermogrow_pkg.sv
// Shared definitions for the thermogrow acquisition path: scheduler state
// encoding, sensor range defaults, sample record and the acceptance rule.
package thermogrow_pkg;

  // Scheduler state encoding (4-bit, kept as plain constants for legacy tools)
  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_STARTUP     = 4'd1;
  localparam logic [3:0] ST_WAIT_PERIOD = 4'd2;
  localparam logic [3:0] ST_START       = 4'd3;
  localparam logic [3:0] ST_WAIT_DONE   = 4'd4;
  localparam logic [3:0] ST_CHECK       = 4'd5;
  localparam logic [3:0] ST_PUBLISH     = 4'd6;
  localparam logic [3:0] ST_FAIL        = 4'd7;
  localparam logic [3:0] ST_RETRY_WAIT  = 4'd8;

  // DHT11 plausible range defaults
  localparam int TEMP_MAX_C = 60;
  localparam int HUM_MAX_RH = 99;

  // The decimal bytes of a DHT11 are tenths, so anything above 9 is corrupt
  localparam logic [7:0] DEC_MAX = 8'd9;

  typedef struct packed {
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
  } sample_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A reading is accepted only with a good checksum and every byte in range
  function automatic logic reading_ok(input logic ok, input sample_t s,
                                      input logic [7:0] t_max,
                                      input logic [7:0] h_max);
    return ok && (s.temp_int <= t_max) && (s.hum_int <= h_max) &&
           (s.temp_dec <= DEC_MAX) && (s.hum_dec <= DEC_MAX);
  endfunction

endpackage

// File: rtl/dht11_read_scheduler_if.sv
// Sensor-side link between the read scheduler and the DHT11 interface block.
//
// Handshake: this is a pulse request/response link, not a streaming bus.
// The scheduler raises sensor_start for exactly one cycle to request one
// transaction. The sensor block later raises sensor_done for exactly one
// cycle; sensor_ok and the four data bytes are meaningful only in that
// cycle. A sensor_done that arrives while no request is outstanding is
// dropped by the scheduler.
interface dht11_read_scheduler_if;
  logic       sensor_start;
  logic       sensor_done;
  logic       sensor_ok;
  logic [7:0] temp_int_i;
  logic [7:0] temp_dec_i;
  logic [7:0] hum_int_i;
  logic [7:0] hum_dec_i;

  modport master (
    output sensor_start,
    input  sensor_done, sensor_ok, temp_int_i, temp_dec_i, hum_int_i, hum_dec_i
  );

  modport slave (
    input  sensor_start,
    output sensor_done, sensor_ok, temp_int_i, temp_dec_i, hum_int_i, hum_dec_i
  );
endinterface

// File: rtl/ms_tick_gen.sv
// 1 ms tick divider. clear restarts the count so a delay measured from a
// state entry is a whole number of milliseconds.
module ms_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, restarted on reset or clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: paces reads, supervises each transaction with a
// timeout, retries failures, range-checks readings and publishes the last
// good sample to the LCD and fan consumers.
module dht11_read_scheduler
  import thermogrow_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int STARTUP_MS   = 1000,
  parameter int PERIOD_MS    = 2000,
  parameter int TIMEOUT_MS   = 20,
  parameter int RETRY_GAP_MS = 1100,
  parameter int MAX_RETRY    = 3,
  parameter int TEMP_MAX     = TEMP_MAX_C,
  parameter int HUM_MAX      = HUM_MAX_RH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  dht11_read_scheduler_if.master sens,
  output logic [7:0]            temp_int_o,
  output logic [7:0]            temp_dec_o,
  output logic [7:0]            hum_int_o,
  output logic [7:0]            hum_dec_o,
  output logic                  data_valid,
  output logic                  lcd_update,
  output logic                  sensor_fault,
  output logic [7:0]            fail_count,
  output logic [3:0]            state_dbg
);

  localparam int MS_MAX = max2(max2(STARTUP_MS, PERIOD_MS), max2(TIMEOUT_MS, RETRY_GAP_MS));
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam int RC_W   = $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(MAX_RETRY - 1);

  logic [3:0]      state;
  logic [3:0]      state_next;
  logic [MS_W-1:0] ms_cnt;
  logic            ms_last;
  logic            tick;
  logic            tick_clear;
  sample_t         shadow;
  logic            shadow_ok;
  logic            pass;
  logic [RC_W-1:0] consec;

  // Every state change restarts the divider so each wait is whole ms
  assign tick_clear = (state_next != state);
  assign ms_last    = (ms_cnt <= MS_W'(1));
  assign pass       = reading_ok(shadow_ok, shadow, 8'(TEMP_MAX), 8'(HUM_MAX));

  assign sens.sensor_start = (state == ST_START);
  assign state_dbg         = state;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Next-state decode; enable is honoured only outside an active read
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:
        if (enable) state_next = ST_STARTUP;
      ST_STARTUP, ST_WAIT_PERIOD, ST_RETRY_WAIT:
        if (!enable)               state_next = ST_IDLE;
        else if (tick && ms_last)  state_next = ST_START;
      ST_START:
        state_next = ST_WAIT_DONE;
      ST_WAIT_DONE:
        // done wins over a timeout expiring in the same cycle
        if (sens.sensor_done)      state_next = ST_CHECK;
        else if (tick && ms_last)  state_next = ST_FAIL;
      ST_CHECK:
        state_next = pass ? ST_PUBLISH : ST_FAIL;
      ST_PUBLISH:
        state_next = enable ? ST_WAIT_PERIOD : ST_IDLE;
      ST_FAIL:
        state_next = enable ? ST_RETRY_WAIT : ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  // State register and millisecond down-counter, reloaded on state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ms_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        case (state_next)
          ST_STARTUP:     ms_cnt <= MS_W'(STARTUP_MS);
          ST_WAIT_PERIOD: ms_cnt <= MS_W'(PERIOD_MS);
          ST_RETRY_WAIT:  ms_cnt <= MS_W'(RETRY_GAP_MS);
          ST_WAIT_DONE:   ms_cnt <= MS_W'(TIMEOUT_MS);
          default:        ms_cnt <= ms_cnt;
        endcase
      end else if (tick && (ms_cnt != '0)) begin
        ms_cnt <= ms_cnt - MS_W'(1);
      end
    end
  end

  // Capture the raw reading only while a transaction is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      shadow_ok <= 1'b0;
    end else if ((state == ST_WAIT_DONE) && sens.sensor_done) begin
      shadow    <= '{temp_int: sens.temp_int_i, temp_dec: sens.temp_dec_i,
                     hum_int:  sens.hum_int_i,  hum_dec:  sens.hum_dec_i};
      shadow_ok <= sens.sensor_ok;
    end
  end

  // Publish accepted samples; lcd_update pulses with the new data
  always_ff @(posedge clk) begin
    if (rst) begin
      temp_int_o <= '0;
      temp_dec_o <= '0;
      hum_int_o  <= '0;
      hum_dec_o  <= '0;
      data_valid <= 1'b0;
      lcd_update <= 1'b0;
    end else begin
      lcd_update <= (state == ST_PUBLISH);
      if (state == ST_PUBLISH) begin
        temp_int_o <= shadow.temp_int;
        temp_dec_o <= shadow.temp_dec;
        hum_int_o  <= shadow.hum_int;
        hum_dec_o  <= shadow.hum_dec;
        data_valid <= 1'b1;
      end
    end
  end

  // Failure bookkeeping: lifetime count and consecutive-failure fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_count   <= '0;
      consec       <= '0;
      sensor_fault <= 1'b0;
    end else if (state == ST_PUBLISH) begin
      consec       <= '0;
      sensor_fault <= 1'b0;
    end else if (state == ST_FAIL) begin
      if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
      if (consec != RC_MAX)    consec     <= consec + RC_W'(1);
      if (consec >= RC_LAST)   sensor_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Bench for dht11_read_scheduler with a 1-cycle ms tick. Expected outputs
// and start spacing come from a transaction-level model of the scheduling
// rules: each ms delay occupies N cycles, and the single-cycle steps
// (leaving IDLE, START, CHECK, PUBLISH/FAIL) each add one cycle.
module tb_dht11_read_scheduler;

  localparam int CLK_HZ       = 1000;
  localparam int STARTUP_MS   = 5;
  localparam int PERIOD_MS    = 10;
  localparam int TIMEOUT_MS   = 4;
  localparam int RETRY_GAP_MS = 6;
  localparam int MAX_RETRY    = 3;
  localparam int TEMP_MAX     = 60;
  localparam int HUM_MAX      = 99;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] temp_int_o, temp_dec_o, hum_int_o, hum_dec_o;
  logic       data_valid, lcd_update, sensor_fault;
  logic [7:0] fail_count;
  logic [3:0] state_dbg;

  dht11_read_scheduler_if sif();

  dht11_read_scheduler #(
    .CLK_HZ(CLK_HZ), .STARTUP_MS(STARTUP_MS), .PERIOD_MS(PERIOD_MS),
    .TIMEOUT_MS(TIMEOUT_MS), .RETRY_GAP_MS(RETRY_GAP_MS),
    .MAX_RETRY(MAX_RETRY), .TEMP_MAX(TEMP_MAX), .HUM_MAX(HUM_MAX)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sens(sif),
    .temp_int_o(temp_int_o), .temp_dec_o(temp_dec_o),
    .hum_int_o(hum_int_o), .hum_dec_o(hum_dec_o),
    .data_valid(data_valid), .lcd_update(lcd_update),
    .sensor_fault(sensor_fault), .fail_count(fail_count),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int lcd_cnt  = 0;
  logic [7:0] exp_q[$];  // expected {temp_int,temp_dec,hum_int,hum_dec} of last good sample
  logic [7:0] exp_t, exp_td, exp_h, exp_hd;
  logic       exp_valid;
  int         exp_fail;
  int         exp_consec;
  int         exp_lcd;
  int         next_gap;

  always @(negedge clk) if (lcd_update === 1'b1) lcd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    sif.sensor_done = 1'b0;
    sif.sensor_ok   = 1'b0;
    sif.temp_int_i  = 8'($urandom_range(0, 255));
    sif.temp_dec_i  = 8'($urandom_range(0, 255));
    sif.hum_int_i   = 8'($urandom_range(0, 255));
    sif.hum_dec_i   = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_done(input logic ok, input logic [7:0] t, td, h, hd);
    sif.sensor_done = 1'b1;
    sif.sensor_ok   = ok;
    sif.temp_int_i  = t;
    sif.temp_dec_i  = td;
    sif.hum_int_i   = h;
    sif.hum_dec_i   = hd;
    step();
    idle_inputs();
  endtask

  // Waits for the next sensor_start and checks it came exactly n cycles on
  task automatic expect_start(input int n, input string tag);
    int k;
    k = 0;
    while (k < n + 20) begin
      step();
      k++;
      if (sif.sensor_start === 1'b1) break;
    end
    chk(tag, 32'(k), 32'(n));
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_temp_int"}, temp_int_o, exp_t);
    chk({tag, "_temp_dec"}, temp_dec_o, exp_td);
    chk({tag, "_hum_int"},  hum_int_o,  exp_h);
    chk({tag, "_hum_dec"},  hum_dec_o,  exp_hd);
    chk({tag, "_valid"},    data_valid, exp_valid);
    chk({tag, "_fail_cnt"}, fail_count, 32'(exp_fail));
    chk({tag, "_fault"},    sensor_fault, (exp_consec >= MAX_RETRY) ? 1 : 0);
  endtask

  task automatic model_reset();
    exp_t = 0; exp_td = 0; exp_h = 0; exp_hd = 0;
    exp_valid = 1'b0; exp_fail = 0; exp_consec = 0;
    exp_q.delete();
  endtask

  // Called at the cycle sensor_start is seen. d = cycles from start to done
  // (1..TIMEOUT_MS), or 0 for no response. Ends at the cycle the result is
  // visible and leaves the expected distance to the next start in next_gap.
  task automatic run_txn(input int d, input logic ok, input logic [7:0] t, td, h, hd,
                         input string tag);
    logic pass;
    step();
    chk({tag, "_start_width"}, sif.sensor_start, 0);
    if (d > 0) begin
      repeat (d - 1) step();
      pulse_done(ok, t, td, h, hd);
      repeat (2) step();
    end else begin
      repeat (TIMEOUT_MS + 1) step();
    end
    pass = (d > 0) && ok && (t <= TEMP_MAX) && (h <= HUM_MAX) && (td <= 9) && (hd <= 9);
    if (pass) begin
      exp_q = '{t, td, h, hd};
      exp_t = exp_q[0]; exp_td = exp_q[1]; exp_h = exp_q[2]; exp_hd = exp_q[3];
      exp_valid = 1'b1;
      exp_consec = 0;
      exp_lcd++;
      next_gap = PERIOD_MS;
    end else begin
      exp_fail   = (exp_fail == 255) ? 255 : exp_fail + 1;
      exp_consec = (exp_consec == MAX_RETRY) ? MAX_RETRY : exp_consec + 1;
      next_gap = RETRY_GAP_MS;
    end
    chk({tag, "_lcd"}, lcd_update, pass);
    check_outputs(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int seen;
    int kind, d;
    logic ok;
    logic [7:0] t, td, h, hd;

    exp_lcd = 0;
    next_gap = 0;
    model_reset();
    rst = 1'b1;
    enable = 1'b0;
    idle_inputs();
    repeat (3) step();

    // Reset state
    chk("rst_start", sif.sensor_start, 0);
    chk("rst_lcd", lcd_update, 0);
    check_outputs("rst");

    // First start STARTUP_MS after enable (plus the IDLE exit cycle)
    rst = 1'b0;
    enable = 1'b1;
    expect_start(STARTUP_MS + 1, "first_start");

    // Three silent reads: timeouts, fault after the third, data stays invalid
    for (int i = 0; i < 3; i++) begin
      run_txn(0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, "timeout");
      expect_start(next_gap, "retry_gap");
    end

    // Good read clears the fault
    run_txn(2, 1'b1, 8'd25, 8'd3, 8'd60, 8'd0, "good_25_3");
    expect_start(next_gap, "period_gap");
    run_txn(2, 1'b1, 8'd30, 8'd0, 8'd55, 8'd5, "good_30");
    expect_start(next_gap, "period_gap2");

    // Rejections: bad checksum and each out-of-range byte
    run_txn(1, 1'b0, 8'd20, 8'd1, 8'd40, 8'd1, "rej_ok");
    expect_start(next_gap, "rej_gap1");
    run_txn(3, 1'b1, 8'd61, 8'd0, 8'd40, 8'd0, "rej_temp61");
    expect_start(next_gap, "rej_gap2");
    run_txn(2, 1'b1, 8'd20, 8'd0, 8'd100, 8'd0, "rej_hum100");
    expect_start(next_gap, "rej_gap3");
    run_txn(2, 1'b1, 8'd20, 8'd10, 8'd40, 8'd0, "rej_tdec10");
    expect_start(next_gap, "rej_gap4");

    // Boundary values accepted, done in the timeout-expiry cycle
    run_txn(TIMEOUT_MS, 1'b1, 8'd60, 8'd9, 8'd99, 8'd9, "edge_accept");

    // sensor_done during WAIT_PERIOD is ignored and does not shift timing
    repeat (3) step();
    pulse_done(1'b1, 8'd11, 8'd1, 8'd22, 8'd2);
    check_outputs("stray_done");
    expect_start(next_gap - 4, "stray_gap");

    // enable dropped during WAIT_DONE: read completes, then idles
    enable = 1'b0;
    run_txn(2, 1'b1, 8'd21, 8'd4, 8'd45, 8'd6, "dis_in_read");
    seen = 0;
    repeat (30) begin
      step();
      if (sif.sensor_start === 1'b1) seen++;
    end
    chk("idle_no_start", 32'(seen), 0);
    enable = 1'b1;
    expect_start(STARTUP_MS + 1, "reenable_start");

    // enable dropped during a wait: back to IDLE, restart via STARTUP
    run_txn(1, 1'b1, 8'd22, 8'd0, 8'd50, 8'd0, "pre_dis");
    enable = 1'b0;
    seen = 0;
    repeat (25) begin
      step();
      if (sif.sensor_start === 1'b1) seen++;
    end
    chk("wait_dis_no_start", 32'(seen), 0);
    enable = 1'b1;
    expect_start(STARTUP_MS + 1, "reenable_start2");

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      d    = (kind < 2) ? 0 : $urandom_range(1, TIMEOUT_MS);
      ok   = ($urandom_range(0, 5) != 0);
      t    = 8'($urandom_range(0, 70));
      td   = 8'($urandom_range(0, 12));
      h    = 8'($urandom_range(0, 110));
      hd   = 8'($urandom_range(0, 12));
      run_txn(d, ok, t, td, h, hd, "rand");
      expect_start(next_gap, "rand_gap");
    end

    // Reset during WAIT_DONE, then a late done: nothing captured
    step();
    rst = 1'b1;
    repeat (2) step();
    model_reset();
    check_outputs("mid_rst");
    rst = 1'b0;
    pulse_done(1'b1, 8'd33, 8'd3, 8'd44, 8'd4);
    expect_start(STARTUP_MS, "post_rst_start");
    check_outputs("post_rst");

    // Lifetime failure counter saturates at 255
    for (int i = 0; i < 256; i++) begin
      run_txn(0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, "sat");
      expect_start(next_gap, "sat_gap");
    end
    chk("sat_final", fail_count, 255);

    #1;
    chk("lcd_total", 32'(lcd_cnt), 32'(exp_lcd));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
